// File: rtl/pal_pkg.sv
// Shared types for the palindrome window statistics block.
//   pal_win_state_e : window FSM states
//   pal_win_res_t   : one completed-window result as stored in the output buffer
// Optional: PAL_WIN_TIMESTAMP_EN adds a per-result completed-window index.
package pal_pkg;

  // Result fields are sized for the largest supported window (WINDOW_LEN <= 255);
  // the top zero-extends into them and narrows on the way out.
  localparam int PAL_CNT_W = 8;
  localparam int WIN_IDX_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } pal_win_state_e;

  typedef struct packed {
    logic [PAL_CNT_W-1:0] cnt;
    logic [PAL_CNT_W-1:0] run_max;
`ifdef PAL_WIN_TIMESTAMP_EN
    logic [WIN_IDX_W-1:0] win_idx;
`endif
  } pal_win_res_t;

endpackage

// File: rtl/pal_res_fifo2.sv
// Two-entry result buffer with sticky overflow.
//   clk, reset   : clock, async active-high reset
//   i_push/i_data: offered result; dropped when full and not popping
//   i_pop        : head consumed (ignored when empty)
//   i_clr_ovf    : clears sticky overflow (a coincident drop wins)
//   o_data       : head entry; holds last value when empty
//   o_full/o_empty, o_ovf
// Entry 0 is always the head, so popping the last entry leaves its data
// visible on o_data.
module pal_res_fifo2
  import pal_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  pal_win_res_t i_data,
  input  logic         i_pop,
  input  logic         i_clr_ovf,
  output pal_win_res_t o_data,
  output logic         o_full,
  output logic         o_empty,
  output logic         o_ovf
);

  pal_win_res_t r_mem [2];
  logic [1:0]   r_count;
  logic         r_ovf;

  logic       w_pop;
  logic       w_drop;
  logic       w_push_ok;
  logic [1:0] w_cnt_after_pop;

  assign o_empty         = (r_count == 2'd0);
  assign o_full          = (r_count == 2'd2);
  assign w_pop           = i_pop && !o_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_drop          = i_push && o_full && !w_pop;
  assign w_push_ok       = i_push && !w_drop;
  assign w_cnt_after_pop = r_count - {1'b0, w_pop};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_count  <= 2'd0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_pop && o_full) r_mem[0] <= r_mem[1];
      // Push lands in the first slot free after this cycle's pop.
      if (w_push_ok) r_mem[w_cnt_after_pop[0]] <= i_data;
      r_count <= w_cnt_after_pop + {1'b0, w_push_ok};
      if (w_drop)         r_ovf <= 1'b1;
      else if (i_clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign o_data = r_mem[0];
  assign o_ovf  = r_ovf;

endmodule

// File: rtl/pal_window_stats.sv
// Per-window statistics over the serial palindrome detection stream.
//   clk, reset : clock, async active-high reset
//   en_i       : accumulate while high; dropping it mid-window aborts the window
//   det_i      : detection bit, one per cycle
//   clr_ovf_i  : clears ovf_o
//   vld_o/rdy_i: result handshake; cnt_o/run_max_o valid when vld_o
//   ovf_o      : sticky, a completed window was dropped on a full buffer
//   win_idx_o  : (PAL_WIN_TIMESTAMP_EN only) completed-window index of the result
// WINDOW_LEN must be in 2..255.
module pal_window_stats
  import pal_pkg::*;
#(
  parameter  int WINDOW_LEN = 16,
  localparam int CNT_W      = $clog2(WINDOW_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             det_i,
  input  logic             clr_ovf_i,
  output logic             vld_o,
  input  logic             rdy_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] run_max_o,
`ifdef PAL_WIN_TIMESTAMP_EN
  output logic [WIN_IDX_W-1:0] win_idx_o,
`endif
  output logic             ovf_o
);

  pal_win_state_e r_state, w_state_nxt;

  logic [CNT_W-1:0] r_bit_idx, r_cnt, r_run, r_run_max;
  logic [CNT_W-1:0] w_cnt_nxt, w_run_nxt, w_run_max_nxt;
  logic             w_last;
  pal_win_res_t     w_push_res, w_head;
  logic             w_full, w_empty;
  logic             w_unused;

  // The FSM only tracks whether a window is open; accumulation is gated by
  // en_i directly so the first cycle en_i is seen high is already slot 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (en_i)  w_state_nxt = COUNT;
      COUNT:   if (!en_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_cnt_nxt     = r_cnt + CNT_W'(det_i);
  assign w_run_nxt     = det_i ? r_run + 1'b1 : '0;
  assign w_run_max_nxt = (w_run_nxt > r_run_max) ? w_run_nxt : r_run_max;
  assign w_last        = en_i && (r_bit_idx == CNT_W'(WINDOW_LEN - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_idx <= '0;
      r_cnt     <= '0;
      r_run     <= '0;
      r_run_max <= '0;
    end else if (!en_i || w_last) begin
      // Abort or completion: next window (if any) starts from scratch.
      r_bit_idx <= '0;
      r_cnt     <= '0;
      r_run     <= '0;
      r_run_max <= '0;
    end else begin
      r_bit_idx <= r_bit_idx + 1'b1;
      r_cnt     <= w_cnt_nxt;
      r_run     <= w_run_nxt;
      r_run_max <= w_run_max_nxt;
    end
  end

`ifdef PAL_WIN_TIMESTAMP_EN
  // Counts every completed window, dropped ones included.
  logic [WIN_IDX_W-1:0] r_win_idx;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_win_idx <= '0;
    else if (w_last) r_win_idx <= r_win_idx + 1'b1;
  end
`endif

  always_comb begin
    w_push_res         = '0;
    w_push_res.cnt     = PAL_CNT_W'(w_cnt_nxt);
    w_push_res.run_max = PAL_CNT_W'(w_run_max_nxt);
`ifdef PAL_WIN_TIMESTAMP_EN
    w_push_res.win_idx = r_win_idx;
`endif
  end

  pal_res_fifo2 u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_last),
    .i_data    (w_push_res),
    .i_pop     (rdy_i),
    .i_clr_ovf (clr_ovf_i),
    .o_data    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_ovf     (ovf_o)
  );

  assign vld_o     = !w_empty;
  assign cnt_o     = w_head.cnt[CNT_W-1:0];
  assign run_max_o = w_head.run_max[CNT_W-1:0];
`ifdef PAL_WIN_TIMESTAMP_EN
  assign win_idx_o = w_head.win_idx;
`endif

  // Upper result bits above CNT_W and the full flag are not needed here.
  assign w_unused = ^{w_head, w_full};

endmodule

// File: tb/tb_pal_window_stats.sv
module tb_pal_window_stats;

  localparam int WL    = 16;
  localparam int CNT_W = $clog2(WL + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             en_i = 1'b0, det_i = 1'b0, clr_ovf_i = 1'b0, rdy_i = 1'b0;
  logic             vld_o, ovf_o;
  logic [CNT_W-1:0] cnt_o, run_max_o;
`ifdef PAL_WIN_TIMESTAMP_EN
  logic [7:0]       win_idx_o;
`endif

  pal_window_stats #(.WINDOW_LEN(WL)) dut (
    .clk       (clk),
    .reset     (reset),
    .en_i      (en_i),
    .det_i     (det_i),
    .clr_ovf_i (clr_ovf_i),
    .vld_o     (vld_o),
    .rdy_i     (rdy_i),
    .cnt_o     (cnt_o),
    .run_max_o (run_max_o),
`ifdef PAL_WIN_TIMESTAMP_EN
    .win_idx_o (win_idx_o),
`endif
    .ovf_o     (ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int rmax;
    int idx;
  } exp_t;

  exp_t       q[$];
  int         n_cmp = 0;
  int         n_mis = 0;
  logic [7:0] m_idx = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one full window; model computes the expected statistics.
  task automatic drive_window(input logic [WL-1:0] pat, input bit exp_push, input bit rdy_last);
    exp_t e;
    int   run;
    e.cnt = 0; e.rmax = 0; e.idx = int'(m_idx); run = 0;
    for (int s = 0; s < WL; s++) begin
      if (pat[s]) begin
        e.cnt++;
        run++;
        if (run > e.rmax) e.rmax = run;
      end else begin
        run = 0;
      end
    end
    if (exp_push) q.push_back(e);
    m_idx = m_idx + 8'd1;
    for (int s = 0; s < WL; s++) begin
      en_i  = 1'b1;
      det_i = pat[s];
      if (rdy_last && s == WL - 1) rdy_i = 1'b1;
      tick();
    end
  endtask

  // Scoreboard consumer: a transfer happens on the edge following this sample.
  always @(negedge clk) begin
    if (!reset && vld_o && rdy_i) begin
      if (q.size() == 0) begin
        chk("spurious_vld", {31'd0, vld_o}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("cnt", 32'(cnt_o), e.cnt);
        chk("run_max", 32'(run_max_o), e.rmax);
`ifdef PAL_WIN_TIMESTAMP_EN
        chk("win_idx", 32'(win_idx_o), e.idx);
`endif
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_vld", {31'd0, vld_o}, 32'd0);
    chk("rst_cnt", 32'(cnt_o), 32'd0);
    chk("rst_run", 32'(run_max_o), 32'd0);
    chk("rst_ovf", {31'd0, ovf_o}, 32'd0);
    reset = 1'b0;
    tick();

    // Basic window: slots 3,4,5,9 -> cnt 4, run 3, one cycle after slot 15
    rdy_i = 1'b1;
    drive_window(16'h0238, 1, 0);
    en_i = 1'b0; det_i = 1'b0;
    chk("lat_vld", {31'd0, vld_o}, 32'd1);
    chk("lat_cnt", 32'(cnt_o), 32'd4);
    chk("lat_run", 32'(run_max_o), 32'd3);
    chk("lat_ovf", {31'd0, ovf_o}, 32'd0);
    tick();
    chk("pop_vld", {31'd0, vld_o}, 32'd0);

    // Saturated window then empty window, back to back
    drive_window(16'hFFFF, 1, 0);
    drive_window(16'h0000, 1, 0);
    en_i = 1'b0; det_i = 1'b0;
    repeat (3) tick();

    // Back-pressure: two held, third dropped
    rdy_i = 1'b0;
    drive_window(16'h000F, 1, 0);
    drive_window(16'h0F0F, 1, 0);
    drive_window(16'h5555, 0, 0);
    en_i = 1'b0; det_i = 1'b0;
    chk("ovf_set", {31'd0, ovf_o}, 32'd1);
    chk("full_vld", {31'd0, vld_o}, 32'd1);
    chk("hold_cnt", 32'(cnt_o), 32'd4);
    chk("hold_run", 32'(run_max_o), 32'd4);
    clr_ovf_i = 1'b1;
    tick();
    clr_ovf_i = 1'b0;
    chk("ovf_clr", {31'd0, ovf_o}, 32'd0);
    chk("hold_cnt2", 32'(cnt_o), 32'd4);
    rdy_i = 1'b1;
    repeat (4) tick();
    chk("drain_vld", {31'd0, vld_o}, 32'd0);

    // Full buffer with pop in the completing cycle: no drop
    rdy_i = 1'b0;
    drive_window(16'h0101, 1, 0);
    drive_window(16'h0300, 1, 0);
    drive_window(16'h7000, 1, 1);
    en_i = 1'b0; det_i = 1'b0;
    chk("nodrop_ovf", {31'd0, ovf_o}, 32'd0);
    chk("nodrop_vld", {31'd0, vld_o}, 32'd1);
    repeat (4) tick();
    chk("nodrop_ovf2", {31'd0, ovf_o}, 32'd0);

    // Abort at slot 7 with 5 detections in slots 0..6
    begin
      logic [6:0] ab;
      ab = 7'b1010111;
      for (int s = 0; s < 7; s++) begin
        en_i  = 1'b1;
        det_i = ab[s];
        tick();
      end
    end
    en_i = 1'b0; det_i = 1'b0;
    repeat (WL + 2) tick();
    chk("abort_vld", {31'd0, vld_o}, 32'd0);
    chk("abort_ovf", {31'd0, ovf_o}, 32'd0);
    drive_window(16'h8001, 1, 0);
    en_i = 1'b0; det_i = 1'b0;
    repeat (3) tick();

    // Reset with one buffered result and a window in flight
    rdy_i = 1'b0;
    drive_window(16'h00FF, 0, 0);
    for (int s = 0; s < 5; s++) begin
      en_i  = 1'b1;
      det_i = 1'b1;
      tick();
    end
    chk("pre_rst_vld", {31'd0, vld_o}, 32'd1);
    chk("pre_rst_cnt", 32'(cnt_o), 32'd8);
    reset = 1'b1;
    #1;
    chk("arst_vld", {31'd0, vld_o}, 32'd0);
    chk("arst_ovf", {31'd0, ovf_o}, 32'd0);
    chk("arst_cnt", 32'(cnt_o), 32'd0);
    en_i = 1'b0; det_i = 1'b0;
    m_idx = 8'd0;
    tick();
    tick();
    reset = 1'b0;
    rdy_i = 1'b1;
    tick();
    drive_window(16'h0003, 1, 0);
    en_i = 1'b0; det_i = 1'b0;

    // Bounded drain of anything still expected
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
